// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg -- shared types and defaults for the VRAM arbiter.
//   owner_e : tag carried with each read through the return pipeline.
//   state_e : arbitration FSM states (CPU_FORCE only exists in the
//             VRAM_ARB_STARVE_GUARD_EN build).
//   ADDR_W_DEF / STARVE_LIMIT_DEF : default parameter values.
package vram_arb_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic {
    VGA_PRI   = 1'b0,
    CPU_FORCE = 1'b1
  } state_e;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter -- two-requester arbiter in front of a single-port
// synchronous VRAM. The VGA scan-out reader normally has priority; with the
// optional starvation guard the CPU is forced one slot after waiting
// STARVE_LIMIT consecutive cycles.
//
// Build option: define VRAM_ARB_STARVE_GUARD_EN to compile in the wait
// counter and the CPU_FORCE state. Without it VGA has strict priority.
//
// Ports:
//   clk_vga, rst_n            : clock (rising edge), async active-low reset
//   vga_req/vga_addr          : VGA read request (held until vga_gnt)
//   vga_gnt                   : combinational grant to VGA
//   vga_rvalid/vga_rdata      : read return, two cycles after vga_gnt
//   cpu_req/we/be/addr/wdata  : CPU request (held until cpu_gnt)
//   cpu_gnt                   : combinational grant to CPU
//   cpu_rvalid/cpu_rdata      : read return, two cycles after a read cpu_gnt
//   ram_en/we/be/addr/wdata   : registered VRAM drive, one cycle after grant
//   ram_rdata                 : VRAM read data (valid two cycles after grant)
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  // VGA scan-out read port
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [15:0]       vga_rdata,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [15:0]       cpu_rdata,
  // VRAM port
  output logic              ram_en,
  output logic              ram_we,
  output logic [1:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("vram_arbiter: STARVE_LIMIT must be in 1..255");
  end

  logic w_vga_gnt;
  logic w_cpu_gnt;
  logic w_cpu_win;   // CPU wins a tie this cycle

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e     r_state;
  logic [7:0] r_wait_cnt;
  logic       w_cpu_wait;

  assign w_cpu_win  = (r_state == CPU_FORCE);
  assign w_cpu_wait = cpu_req && !w_cpu_gnt;

  // The state flips on the same edge the counter reaches the limit, so the
  // forced slot lands in the very next cycle (8 VGA slots, then the CPU).
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= VGA_PRI;
      r_wait_cnt <= '0;
    end else begin
      if (!w_cpu_wait) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != LIMIT) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end

      case (r_state)
        VGA_PRI: begin
          if (w_cpu_wait && (r_wait_cnt >= LIMIT - 8'd1)) begin
            r_state <= CPU_FORCE;
          end
        end
        CPU_FORCE: begin
          if (w_cpu_gnt || !cpu_req) begin
            r_state <= VGA_PRI;
          end
        end
        default: r_state <= VGA_PRI;
      endcase
    end
  end
`else
  assign w_cpu_win = 1'b0;
`endif

  // Grants are gated by rst_n so nothing is granted while reset is held.
  assign w_cpu_gnt = rst_n && cpu_req && (!vga_req || w_cpu_win);
  assign w_vga_gnt = rst_n && vga_req && !w_cpu_gnt;

  assign vga_gnt = w_vga_gnt;
  assign cpu_gnt = w_cpu_gnt;

  logic              r_ram_en;
  logic              r_ram_we;
  logic [1:0]        r_ram_be;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [15:0]       r_ram_wdata;
  owner_e            r_own_p0;
  owner_e            r_own_p1;

  // Stage p0: register the granted access onto the VRAM pins and tag its
  // owner. Stage p1: the tag lines up with ram_rdata from the VRAM.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_be    <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_own_p0    <= OWN_NONE;
      r_own_p1    <= OWN_NONE;
    end else begin
      r_own_p1 <= r_own_p0;
      if (w_vga_gnt) begin
        r_ram_en   <= 1'b1;
        r_ram_we   <= 1'b0;
        r_ram_be   <= 2'b11;
        r_ram_addr <= vga_addr;
        r_own_p0   <= OWN_VGA;
      end else if (w_cpu_gnt) begin
        r_ram_en    <= 1'b1;
        r_ram_we    <= cpu_we;
        r_ram_be    <= cpu_be;
        r_ram_addr  <= cpu_addr;
        r_ram_wdata <= cpu_wdata;
        r_own_p0    <= cpu_we ? OWN_NONE : OWN_CPU;
      end else begin
        // Idle: address and write data hold to avoid needless toggling.
        r_ram_en <= 1'b0;
        r_ram_we <= 1'b0;
        r_own_p0 <= OWN_NONE;
      end
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_be    = r_ram_be;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

  assign vga_rvalid = (r_own_p1 == OWN_VGA);
  assign cpu_rvalid = (r_own_p1 == OWN_CPU);
  assign vga_rdata  = ram_rdata;
  assign cpu_rdata  = ram_rdata;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: VRAM word-address width.
REQ-002 Parameter STARVE_LIMIT, default 8, legal range 1..255: number of consecutive CPU wait cycles before the CPU is forced a slot.
REQ-003 Port clk_vga, input, 1: single clock for the block; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Ports for the VGA scan-out read requester: vga_req in 1, vga_addr in ADDR_W, vga_gnt out 1, vga_rvalid out 1, vga_rdata out 16.
REQ-006 Ports for the CPU requester: cpu_req in 1, cpu_we in 1, cpu_be in 2, cpu_addr in ADDR_W, cpu_wdata in 16, cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out 16.
REQ-007 Ports to the single-port synchronous VRAM: ram_en out 1, ram_we out 1, ram_be out 2, ram_addr out ADDR_W, ram_wdata out 16, ram_rdata in 16.

Function
REQ-008 The block shall issue at most one VRAM access per cycle and shall sustain one access per cycle back-to-back.
REQ-009 vga_gnt and cpu_gnt shall be combinational from the current requests and state; they shall be mutually exclusive and never asserted without the matching req.
REQ-010 A requester shall hold req and its address, data and control stable until it sees gnt; the transfer completes in the gnt cycle.
REQ-011 Arbitration rule 1: if only one requester is asserting req, that requester is granted.
REQ-012 Arbitration rule 2: if both are asserting req, the VGA requester wins, except when the arbiter is in state CPU_FORCE, in which case the CPU wins.
REQ-013 FSM states: VGA_PRI (reset state) and CPU_FORCE.
REQ-014 FSM transitions: VGA_PRI goes to CPU_FORCE when the wait counter reaches STARVE_LIMIT; CPU_FORCE goes to VGA_PRI on cpu_gnt, or when cpu_req is deasserted.
REQ-015 Wait counter: 8 bits; increments on each cycle with cpu_req=1 and cpu_gnt=0; saturates at STARVE_LIMIT; clears to 0 on cpu_gnt or on cpu_req=0.
REQ-016 Registered VRAM drive: the ram_* outputs are registered from the granted request, so a grant in cycle N drives ram_en=1 and the granted ram_addr/ram_we/ram_be/ram_wdata in cycle N+1. VGA grants drive ram_we=0 and ram_be=2'b11.
REQ-017 Idle: with no grant in cycle N, cycle N+1 shall have ram_en=0 and ram_we=0; ram_addr and ram_wdata hold their previous values.
REQ-018 Read return: a read granted in cycle N returns with a one-cycle pulse of the owner's rvalid in cycle N+2.
REQ-019 The owner tag shall be carried through a two-stage pipeline (OWN_NONE/OWN_VGA/OWN_CPU) that drives the rvalid outputs.
REQ-020 CPU writes shall produce no cpu_rvalid.
REQ-021 vga_rdata and cpu_rdata shall equal ram_rdata combinationally; they are meaningful only while the matching rvalid is high.
REQ-022 A VGA access may be delayed by at most one cycle by a forced CPU slot.

Reset
REQ-023 While rst_n=0, the following shall be held low: ram_en, ram_we, vga_rvalid, cpu_rvalid, vga_gnt, cpu_gnt.
REQ-024 While rst_n=0: ram_be=0, ram_addr=0, ram_wdata=0, wait counter=0, FSM=VGA_PRI, owner pipeline=OWN_NONE.
REQ-025 Reset asserted mid-operation shall discard in-flight reads; no rvalid shall appear for them after reset is released.

Configuration
REQ-026 With macro VRAM_ARB_STARVE_GUARD_EN defined, the wait counter and the CPU_FORCE state shall be compiled in.
REQ-027 Without VRAM_ARB_STARVE_GUARD_EN, the wait counter and CPU_FORCE shall be absent and VGA has strict priority; the CPU is granted only in cycles with vga_req=0.

Structure
REQ-028 Package vram_arb_pkg shall hold: the owner enum (OWN_NONE, OWN_VGA, OWN_CPU), the FSM state enum, and the default ADDR_W and STARVE_LIMIT constants.
REQ-029 The block is a single module; no sub-module is needed.

Verification
REQ-030 Scenario "VGA read": VGA alone requests addr 0x0010 in cycle 0 -> vga_gnt in cycle 0; ram_en=1, ram_addr=0x0010, ram_we=0 in cycle 1; with ram_rdata=0x1F41, vga_rvalid=1 and vga_rdata=0x1F41 in cycle 2.
REQ-031 Scenario "CPU write": CPU alone writes addr 0x07CF, data 0xA5C3, be=2'b01 -> ram_we=1, ram_be=2'b01, ram_wdata=0xA5C3 one cycle after cpu_gnt; cpu_rvalid never asserted.
REQ-032 Scenario "contention, guard on": both requesters continuously asserting req, STARVE_LIMIT=8 -> VGA granted for 8 cycles, CPU granted in cycle 8, VGA granted again in cycle 9; the pattern repeats.
REQ-033 Scenario "contention, guard off": same stimulus compiled without VRAM_ARB_STARVE_GUARD_EN -> cpu_gnt stays 0 until vga_req drops, then is granted in that same cycle.
REQ-034 Scenario "back-to-back": alternating VGA read and CPU read grants in cycles 0..3 -> rvalid pulses in cycles 2..5 with the owners alternating and no gaps.
REQ-035 Scenario "reset mid-read": rst_n asserted in cycle 1 after a grant in cycle 0 -> no rvalid after reset is released; all outputs at their reset values.
